// File: rtl/vdp_cpu_if.sv
// vdp_cpu_if: Z80-side front end of a TMS9918-style VDP (I/O decode, address counter, registers, status).
// Optional VDP_LATCH_CLEAR_EN: data-port accesses and status reads also reset the control latch flag.

module vdp_cpu_if #(
   parameter logic [7:0]  DATA_PORT = 8'hBE,
   parameter logic [7:0]  CTRL_PORT = 8'hBF,
   parameter int unsigned ADDR_BITS = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_ce,
   input  logic [7:0]           cpu_addr,
   input  logic [7:0]           cpu_dout,
   input  logic                 n_iowr,
   input  logic                 n_iord,
   output logic [7:0]           cpu_din,
   output logic                 cpu_din_sel,
   output logic [ADDR_BITS-1:0] vram_addr,
   output logic [7:0]           vram_wdata,
   output logic                 vram_we,
   output logic                 vram_re,
   input  logic [7:0]           vram_rdata,
   input  logic                 vram_rvalid,
   output logic [63:0]          regs,
   input  logic                 int_set,
   input  logic                 coll_set,
   input  logic                 fifth_set,
   input  logic [4:0]           fifth_num,
   output logic                 int_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } pf_state_t;

   pf_state_t             state, state_next;
   logic                  hit_dwr, hit_drd, hit_cwr, hit_crd;
   logic [3:0]            hit_prev;
   logic                  ev_dwr, ev_drd, ev_cwr, ev_crd, st_clr;
   logic                  latch_rst, pf_req, buf_load;
   logic                  latch_flag;
   logic [7:0]            first_byte;
   logic [ADDR_BITS-1:0]  addr_cnt, wr_addr;
   logic [7:0][7:0]       reg_file;
   logic [7:0]            rd_buf;
   logic                  int_flag, coll_flag, fifth_flag;
   logic [4:0]            fifth_q;
   logic [7:0]            status;

   assign hit_dwr = (cpu_addr == DATA_PORT) && !n_iowr;
   assign hit_drd = (cpu_addr == DATA_PORT) && !n_iord;
   assign hit_cwr = (cpu_addr == CTRL_PORT) && !n_iowr;
   assign hit_crd = (cpu_addr == CTRL_PORT) && !n_iord;

   // Edge-detect each access condition on the CPU strobe so a multi-cycle I/O cycle acts once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_prev <= '0;
      end else if (cpu_ce) begin
         hit_prev <= {hit_crd, hit_cwr, hit_drd, hit_dwr};
      end
   end

   assign ev_dwr = cpu_ce && hit_dwr && !hit_prev[0];
   assign ev_drd = cpu_ce && hit_drd && !hit_prev[1];
   assign ev_cwr = cpu_ce && hit_cwr && !hit_prev[2];
   assign ev_crd = cpu_ce && hit_crd && !hit_prev[3];
   assign st_clr = cpu_ce && hit_prev[3] && !hit_crd;

`ifdef VDP_LATCH_CLEAR_EN
   assign latch_rst = ev_dwr || ev_drd || ev_crd;
`else
   assign latch_rst = 1'b0;
`endif

   assign pf_req = (ev_cwr && latch_flag && (cpu_dout[7:6] == 2'b00)) || ev_drd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_flag <= 1'b0;
         first_byte <= '0;
         addr_cnt   <= '0;
         reg_file   <= '0;
      end else if (ev_cwr) begin
         if (!latch_flag) begin
            first_byte <= cpu_dout;
            latch_flag <= 1'b1;
         end else begin
            latch_flag <= 1'b0;
            if (cpu_dout[7])
               reg_file[cpu_dout[2:0]] <= first_byte;
            else
               addr_cnt <= ADDR_BITS'({cpu_dout[5:0], first_byte});
         end
      end else begin
         if (latch_rst)
            latch_flag <= 1'b0;
         if (ev_dwr || ev_drd)
            addr_cnt <= addr_cnt + ADDR_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vram_we    <= 1'b0;
         vram_wdata <= '0;
         wr_addr    <= '0;
         rd_buf     <= '0;
      end else begin
         vram_we <= ev_dwr;
         if (ev_dwr) begin
            vram_wdata <= cpu_dout;
            wr_addr    <= addr_cnt;
            rd_buf     <= cpu_dout;
         end else if (buf_load) begin
            rd_buf <= vram_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A data write abandons any prefetch; a fresh request restarts it and drops the old rvalid.
   always_comb begin
      state_next = state;
      buf_load   = 1'b0;
      if (ev_dwr) begin
         state_next = IDLE;
      end else if (pf_req) begin
         state_next = REQ;
      end else begin
         case (state)
            IDLE: state_next = IDLE;
            REQ:  state_next = vram_we ? IDLE : WAIT;
            WAIT: begin
               if (vram_rvalid) begin
                  state_next = IDLE;
                  buf_load   = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      vram_re   = (state == REQ) && !vram_we;
      vram_addr = vram_we ? wr_addr : addr_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_flag   <= 1'b0;
         coll_flag  <= 1'b0;
         fifth_flag <= 1'b0;
         fifth_q    <= '0;
      end else begin
         int_flag  <= int_set  || (int_flag  && !st_clr);
         coll_flag <= coll_set || (coll_flag && !st_clr);
         if (fifth_set && !fifth_flag) begin
            fifth_flag <= 1'b1;
            fifth_q    <= fifth_num;
         end else if (st_clr && !fifth_set) begin
            fifth_flag <= 1'b0;
         end
      end
   end

   assign status      = {int_flag, fifth_flag, coll_flag, fifth_flag ? fifth_q : 5'h1F};
   assign cpu_din     = (cpu_addr == CTRL_PORT) ? status : rd_buf;
   assign cpu_din_sel = hit_drd || hit_crd;
   assign regs        = reg_file;
   assign int_n       = !(int_flag && reg_file[1][5]);

endmodule
